// File: rtl/cdb_arbiter_buffer_pkg.sv
// cdb_arbiter_buffer_pkg
//   Shared types and sizes for the CDB completion buffer.
//   - fu_result_t : one execution-unit result {valid, value, dest_prf, rob_idx}
//   - cdb_t       : one CDB broadcast lane, same field layout
//   - to_cdb()    : converts a queued/incoming result into a CDB lane
package cdb_arbiter_buffer_pkg;

  localparam int XLEN          = 32;
  localparam int N             = 4;   // CDB lanes per cycle
  localparam int NUM_FU        = 8;   // FU result ports
  localparam int CDB_BUF_DEPTH = 16;  // power of two, >= NUM_FU + N
  localparam int PRF_BITS      = 6;
  localparam int ROB_BITS      = 5;

  localparam int PTR_W    = $clog2(CDB_BUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int FU_IDX_W = $clog2(NUM_FU);

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     value;
    logic [PRF_BITS-1:0] dest_prf;
    logic [ROB_BITS-1:0] rob_idx;
  } fu_result_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     value;
    logic [PRF_BITS-1:0] dest_prf;
    logic [ROB_BITS-1:0] rob_idx;
  } cdb_t;

  function automatic cdb_t to_cdb(input fu_result_t r);
    cdb_t c;
    c.valid    = r.valid;
    c.value    = r.value;
    c.dest_prf = r.dest_prf;
    c.rob_idx  = r.rob_idx;
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_buffer_if.sv
// cdb_arbiter_buffer_if
//   Result-collection / broadcast bus of the completion buffer.
//   - fu_results   : NUM_FU result ports from the execution units
//   - fu_stall     : backpressure to the execution units
//   - cdb_output   : N registered CDB lanes
//   - buffer_count : current queue occupancy
//
// Handshake: fu_stall is the inverse of ready. A result on port p is
// accepted in a cycle iff fu_results[p].valid && !fu_stall && !nuke; when
// fu_stall is high the FU must hold its result and present it again.
// cdb_output lanes carry no ready: a valid lane is a broadcast that cycle.
interface cdb_arbiter_buffer_if;
  import cdb_arbiter_buffer_pkg::*;

  fu_result_t [NUM_FU-1:0] fu_results;
  logic                    fu_stall;
  cdb_t       [N-1:0]      cdb_output;
  logic       [CNT_W-1:0]  buffer_count;

  // master: execution units + CDB consumers; slave: the buffer itself
  modport master (output fu_results, input fu_stall, cdb_output, buffer_count);
  modport slave  (input fu_results, output fu_stall, cdb_output, buffer_count);
endinterface

// File: rtl/cdb_arbiter_buffer_result_compactor.sv
// cdb_arbiter_buffer_result_compactor
//   Combinational packer: squeezes the valid entries of NUM_FU result ports
//   into a dense list, preserving ascending port order.
//   - in_results     : raw per-port results
//   - packed_results : entries 0..packed_count-1 are the valid inputs
//   - packed_count   : number of valid inputs
module cdb_arbiter_buffer_result_compactor
  import cdb_arbiter_buffer_pkg::*;
(
  input  fu_result_t [NUM_FU-1:0] in_results,
  output fu_result_t [NUM_FU-1:0] packed_results,
  output logic       [CNT_W-1:0]  packed_count
);

  fu_result_t [NUM_FU-1:0] list;
  logic       [CNT_W-1:0]  cnt;

  always_comb begin
    list = '0;
    cnt  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (in_results[i].valid) begin
        // cnt < NUM_FU whenever this write happens, so the low bits suffice
        list[cnt[FU_IDX_W-1:0]] = in_results[i];
        cnt = cnt + CNT_W'(1);
      end
    end
    packed_results = list;
    packed_count   = cnt;
  end

endmodule

// File: rtl/cdb_arbiter_buffer.sv
// cdb_arbiter_buffer
//   Completion stage: gathers FU results, keeps them in age order in a
//   circular queue and broadcasts up to N per cycle on the CDB.
//   - clock, reset : rising-edge clock, asynchronous active-high reset
//   - nuke         : synchronous flush of queue and CDB
//   - bus (slave)  : fu_results in; fu_stall, cdb_output, buffer_count out
module cdb_arbiter_buffer
  import cdb_arbiter_buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 nuke,
  cdb_arbiter_buffer_if.slave  bus
);

  localparam logic [CNT_W-1:0] N_C          = CNT_W'(N);
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(CDB_BUF_DEPTH);
  localparam logic [CNT_W-1:0] STALL_THRESH = CNT_W'(CDB_BUF_DEPTH - NUM_FU);

  fu_result_t              mem_q [CDB_BUF_DEPTH];
  fu_result_t              mem_d [CDB_BUF_DEPTH];
  logic       [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic       [CNT_W-1:0]  count_q, count_d;
  cdb_t       [N-1:0]      cdb_q, cdb_d;

  fu_result_t [NUM_FU-1:0] comp_results;
  logic       [CNT_W-1:0]  comp_count;

  logic                    stall;
  logic       [CNT_W-1:0]  inc_cnt, pop_cnt, avail, inc_bcast, push_cnt;
  logic       [CNT_W-1:0]  lane_c, inc_sel, k_c, src;
  logic       [PTR_W-1:0]  rd_ptr, wr_ptr;

  cdb_arbiter_buffer_result_compactor u_compactor (
    .in_results     (bus.fu_results),
    .packed_results (comp_results),
    .packed_count   (comp_count)
  );

  // Worst case while not stalled: count=DEPTH-NUM_FU, NUM_FU pushed,
  // at least min(N,count) popped, so the queue can never overflow.
  assign stall = (count_q > STALL_THRESH);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cdb_d   = '0;
    mem_d   = mem_q;
    lane_c  = '0;
    inc_sel = '0;
    k_c     = '0;
    src     = '0;
    rd_ptr  = '0;
    wr_ptr  = '0;

    inc_cnt   = (stall || nuke) ? '0 : comp_count;
    pop_cnt   = (count_q > N_C) ? N_C : count_q;
    avail     = N_C - pop_cnt;
    inc_bcast = (inc_cnt > avail) ? avail : inc_cnt;
    push_cnt  = inc_cnt - inc_bcast;

    // Lanes are filled oldest-first: queued entries, then same-cycle inputs.
    for (int l = 0; l < N; l++) begin
      lane_c = CNT_W'(l);
      if (lane_c < pop_cnt) begin
        rd_ptr   = head_q + PTR_W'(l);
        cdb_d[l] = to_cdb(mem_q[rd_ptr]);
      end else begin
        inc_sel = lane_c - pop_cnt;
        if (inc_sel < inc_bcast) begin
          cdb_d[l] = to_cdb(comp_results[inc_sel[FU_IDX_W-1:0]]);
        end
      end
    end

    // Inputs that did not fit on the CDB are appended behind the tail.
    for (int k = 0; k < NUM_FU; k++) begin
      k_c = CNT_W'(k);
      if (k_c < push_cnt) begin
        src           = inc_bcast + k_c;
        wr_ptr        = tail_q + PTR_W'(k);
        mem_d[wr_ptr] = comp_results[src[FU_IDX_W-1:0]];
      end
    end

    head_d  = head_q + pop_cnt[PTR_W-1:0];
    tail_d  = tail_q + push_cnt[PTR_W-1:0];
    count_d = count_q - pop_cnt + push_cnt;

    if (nuke) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cdb_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cdb_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cdb_q   <= cdb_d;
    end
  end

  // Payload storage only; occupancy is tracked by head/tail/count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.fu_stall     = stall;
  assign bus.cdb_output   = cdb_q;
  assign bus.buffer_count = count_q;

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_cdb_arbiter_buffer.sv
module tb_cdb_arbiter_buffer;
  import cdb_arbiter_buffer_pkg::*;

  localparam int EW = XLEN + PRF_BITS;

  logic clock = 1'b0;
  logic reset;
  logic nuke;

  cdb_arbiter_buffer_if bus();

  cdb_arbiter_buffer dut (
    .clock (clock),
    .reset (reset),
    .nuke  (nuke),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];   // {value, dest_prf} in expected broadcast order

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    bus.fu_results = '0;
  endtask

  task automatic drive_port(input int p, input logic [XLEN-1:0] v,
                            input logic [PRF_BITS-1:0] d, input logic [ROB_BITS-1:0] r);
    bus.fu_results[p].valid    = 1'b1;
    bus.fu_results[p].value    = v;
    bus.fu_results[p].dest_prf = d;
    bus.fu_results[p].rob_idx  = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    nuke  = 1'b0;
    clear_inputs();
    step();
    step();
    for (int l = 0; l < N; l++) begin
      n_cmp++;
      if (bus.cdb_output[l] !== cdb_t'(0)) begin
        n_err++;
        $display("FAIL reset_lane%0d: got %h expected 0", l, bus.cdb_output[l]);
      end
    end
    n_cmp++;
    if (bus.fu_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b expected 0", bus.fu_stall);
    end
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(0)) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", bus.buffer_count);
    end
    #2 reset = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.cdb_output[0].valid !== 1'b0 || bus.buffer_count !== CNT_W'(0)) begin
      n_err++;
      $display("FAIL idle_after_reset: got valid=%b count=%0d expected valid=0 count=0",
               bus.cdb_output[0].valid, bus.buffer_count);
    end
  endtask

  task automatic test_single;
    cdb_t exp_lane;
    clear_inputs();
    drive_port(3, 32'h4, 6'h1, 5'd2);
    step();
    clear_inputs();
    exp_lane = '{valid: 1'b1, value: 32'h4, dest_prf: 6'h1, rob_idx: 5'd2};
    n_cmp++;
    if (bus.cdb_output[0] !== exp_lane) begin
      n_err++; $display("FAIL single_lane0: got %h expected %h", bus.cdb_output[0], exp_lane);
    end
    for (int l = 1; l < N; l++) begin
      n_cmp++;
      if (bus.cdb_output[l].valid !== 1'b0) begin
        n_err++; $display("FAIL single_lane%0d_valid: got 1 expected 0", l);
      end
    end
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(0)) begin
      n_err++; $display("FAIL single_count: got %0d expected 0", bus.buffer_count);
    end
    step();
    n_cmp++;
    if (bus.cdb_output[0].valid !== 1'b0) begin
      n_err++; $display("FAIL single_clear: got valid=1 expected 0");
    end
  endtask

  task automatic test_multi;
    int port_tab[4] = '{0, 2, 5, 6};
    int in_ports[5] = '{0, 2, 5, 6, 7};
    clear_inputs();
    foreach (in_ports[i]) drive_port(in_ports[i], 32'h200 + in_ports[i], 6'(16 + in_ports[i]), 5'(in_ports[i]));
    step();
    clear_inputs();
    for (int l = 0; l < N; l++) begin
      n_cmp++;
      if (bus.cdb_output[l].valid !== 1'b1 ||
          bus.cdb_output[l].dest_prf !== 6'(16 + port_tab[l]) ||
          bus.cdb_output[l].value !== 32'h200 + port_tab[l]) begin
        n_err++;
        $display("FAIL multi_lane%0d: got v=%b dest=%0d expected v=1 dest=%0d", l,
                 bus.cdb_output[l].valid, bus.cdb_output[l].dest_prf, 16 + port_tab[l]);
      end
    end
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(1)) begin
      n_err++; $display("FAIL multi_count1: got %0d expected 1", bus.buffer_count);
    end
    step();
    n_cmp++;
    if (bus.cdb_output[0].valid !== 1'b1 || bus.cdb_output[0].dest_prf !== 6'd23 ||
        bus.cdb_output[0].rob_idx !== 5'd7) begin
      n_err++;
      $display("FAIL multi_port7: got v=%b dest=%0d expected v=1 dest=23",
               bus.cdb_output[0].valid, bus.cdb_output[0].dest_prf);
    end
    for (int l = 1; l < N; l++) begin
      n_cmp++;
      if (bus.cdb_output[l].valid !== 1'b0) begin
        n_err++; $display("FAIL multi_tail_lane%0d: got valid=1 expected 0", l);
      end
    end
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(0)) begin
      n_err++; $display("FAIL multi_count0: got %0d expected 0", bus.buffer_count);
    end
  endtask

  task automatic test_stall;
    int exp_cnt[7]    = '{4, 8, 12, 8, 4, 0, 0};
    bit exp_stall[7]  = '{0, 0, 1, 0, 0, 0, 0};
    int exp_nvalid[7] = '{4, 4, 4, 4, 4, 4, 0};
    int nvalid;
    bit seen_gap;
    logic [EW-1:0] e, got;
    exp_q.delete();
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      if (c < 3) begin
        for (int p = 0; p < NUM_FU; p++) begin
          drive_port(p, 32'h100 + c * 8 + p, 6'(c * 8 + p), 5'(p));
          exp_q.push_back({32'h100 + 32'(c * 8 + p), 6'(c * 8 + p)});
        end
      end else if (c == 3) begin
        // presented while stalled: must never be broadcast
        for (int p = 0; p < NUM_FU; p++) drive_port(p, 32'hDEAD, 6'(40 + p), 5'(p));
      end
      step();
      n_cmp++;
      if (bus.buffer_count !== CNT_W'(exp_cnt[c])) begin
        n_err++; $display("FAIL stall_count_c%0d: got %0d expected %0d", c, bus.buffer_count, exp_cnt[c]);
      end
      n_cmp++;
      if (bus.fu_stall !== exp_stall[c]) begin
        n_err++; $display("FAIL stall_flag_c%0d: got %b expected %b", c, bus.fu_stall, exp_stall[c]);
      end
      nvalid = 0;
      seen_gap = 1'b0;
      for (int l = 0; l < N; l++) begin
        if (bus.cdb_output[l].valid) begin
          nvalid++;
          got = {bus.cdb_output[l].value, bus.cdb_output[l].dest_prf};
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          n_cmp++;
          if (got !== e || seen_gap) begin
            n_err++; $display("FAIL stall_order_c%0d_l%0d: got %h expected %h", c, l, got, e);
          end
        end else begin
          seen_gap = 1'b1;
        end
      end
      n_cmp++;
      if (nvalid != exp_nvalid[c]) begin
        n_err++; $display("FAIL stall_nvalid_c%0d: got %0d expected %0d", c, nvalid, exp_nvalid[c]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL stall_leftover: got %0d unbroadcast expected 0", exp_q.size());
    end
  endtask

  task automatic test_nuke;
    clear_inputs();
    for (int p = 0; p < NUM_FU; p++) drive_port(p, 32'h300 + p, 6'(32 + p), 5'(p));
    step();
    clear_inputs();
    for (int p = 0; p < 6; p++) drive_port(p, 32'h400 + p, 6'(40 + p), 5'(p));
    step();
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(6)) begin
      n_err++; $display("FAIL nuke_pre_count: got %0d expected 6", bus.buffer_count);
    end
    clear_inputs();
    nuke = 1'b1;
    for (int p = 0; p < 4; p++) drive_port(p, 32'h500 + p, 6'(48 + p), 5'(p));
    #1;
    for (int l = 0; l < N; l++) begin
      n_cmp++;
      if (bus.cdb_output[l].valid !== 1'b1 || bus.cdb_output[l].dest_prf !== 6'(36 + l)) begin
        n_err++;
        $display("FAIL nuke_cycle_lane%0d: got v=%b dest=%0d expected v=1 dest=%0d", l,
                 bus.cdb_output[l].valid, bus.cdb_output[l].dest_prf, 36 + l);
      end
    end
    step();
    nuke = 1'b0;
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < N; l++) begin
        n_cmp++;
        if (bus.cdb_output[l].valid !== 1'b0) begin
          n_err++;
          $display("FAIL nuke_stale_c%0d_l%0d: got valid dest=%0d expected invalid", c, l,
                   bus.cdb_output[l].dest_prf);
        end
      end
      n_cmp++;
      if (bus.buffer_count !== CNT_W'(0) || bus.fu_stall !== 1'b0) begin
        n_err++;
        $display("FAIL nuke_count_c%0d: got count=%0d stall=%b expected 0/0", c, bus.buffer_count, bus.fu_stall);
      end
      step();
    end
    drive_port(1, 32'h3A, 6'h3A, 5'd9);
    step();
    clear_inputs();
    n_cmp++;
    if (bus.cdb_output[0].valid !== 1'b1 || bus.cdb_output[0].dest_prf !== 6'h3A ||
        bus.cdb_output[1].valid !== 1'b0) begin
      n_err++;
      $display("FAIL nuke_after: got v0=%b dest=%0d v1=%b expected v0=1 dest=58 v1=0",
               bus.cdb_output[0].valid, bus.cdb_output[0].dest_prf, bus.cdb_output[1].valid);
    end
    step();
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    for (int p = 0; p < NUM_FU; p++) drive_port(p, 32'h600 + p, 6'(p), 5'(p));
    step();
    clear_inputs();
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(4)) begin
      n_err++; $display("FAIL rstmid_pre_count: got %0d expected 4", bus.buffer_count);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.buffer_count !== CNT_W'(0) || bus.cdb_output !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: got count=%0d cdb=%h expected 0", bus.buffer_count, bus.cdb_output);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (bus.cdb_output !== '0 || bus.buffer_count !== CNT_W'(0)) begin
        n_err++;
        $display("FAIL rstmid_after_c%0d: got count=%0d cdb=%h expected 0", c, bus.buffer_count, bus.cdb_output);
      end
    end
  endtask

  task automatic test_wrap;
    int issued, idx, mc, cyc, k, total, nb, nvalid;
    bit stall_m, seen_gap;
    logic [7:0] mask;
    logic [EW-1:0] e, got;
    issued = 0; mc = 0; cyc = 0;
    exp_q.delete();
    while ((issued < 40 || mc > 0) && cyc < 300) begin
      stall_m = (mc > CDB_BUF_DEPTH - NUM_FU);
      n_cmp++;
      if (bus.fu_stall !== stall_m || bus.buffer_count !== CNT_W'(mc)) begin
        n_err++;
        $display("FAIL wrap_state_c%0d: got stall=%b count=%0d expected stall=%b count=%0d",
                 cyc, bus.fu_stall, bus.buffer_count, stall_m, mc);
      end
      clear_inputs();
      idx = issued;
      if ($urandom_range(0, 3) == 0) mask = 8'h00;
      else if ($urandom_range(0, 1) == 1) mask = 8'hFF;
      else mask = 8'($urandom_range(1, 255));
      for (int p = 0; p < NUM_FU; p++) begin
        if (mask[p] && idx < 40) begin
          drive_port(p, 32'hA000 + idx, 6'(idx), 5'(idx));
          idx++;
        end
      end
      k = 0;
      if (!stall_m) begin
        for (int i = issued; i < idx; i++) exp_q.push_back({32'hA000 + 32'(i), 6'(i)});
        k = idx - issued;
        issued = idx;
      end
      step();
      total = mc + k;
      nb = (total > N) ? N : total;
      mc = total - nb;
      nvalid = 0;
      seen_gap = 1'b0;
      for (int l = 0; l < N; l++) begin
        if (bus.cdb_output[l].valid) begin
          nvalid++;
          got = {bus.cdb_output[l].value, bus.cdb_output[l].dest_prf};
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          n_cmp++;
          if (got !== e || seen_gap) begin
            n_err++; $display("FAIL wrap_order_c%0d_l%0d: got %h expected %h", cyc, l, got, e);
          end
        end else begin
          seen_gap = 1'b1;
        end
      end
      n_cmp++;
      if (nvalid != nb || bus.buffer_count > CNT_W'(CDB_BUF_DEPTH)) begin
        n_err++;
        $display("FAIL wrap_nvalid_c%0d: got %0d lanes count=%0d expected %0d lanes count<=16",
                 cyc, nvalid, bus.buffer_count, nb);
      end
      cyc++;
    end
    clear_inputs();
    n_cmp++;
    if (cyc >= 300 || exp_q.size() != 0 || issued != 40) begin
      n_err++;
      $display("FAIL wrap_drain: got cycles=%0d leftover=%0d issued=%0d expected <300/0/40",
               cyc, exp_q.size(), issued);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    nuke  = 1'b0;
    bus.fu_results = '0;
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_nuke();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter_buffer.md
Name: cdb_arbiter_buffer

Overview:
- Completion stage directly downstream of functional_unit.
- Collects finished results from NUM_FU execution-unit result ports, queues them in age order, and broadcasts up to N per cycle on the N-lane CDB.
- Applies backpressure to the FUs when queue space is short.
- Flushes everything on nuke.

Parameters:
- N, 4: CDB lanes per cycle (`N).
- NUM_FU, 8: FU result ports arbitrated.
- DEPTH, 16: queue entries; power of two, >= NUM_FU+N.
- PRF_BITS, 6: physical register index width.
- ROB_BITS, `ROB_NUM_INDEX_BITS: ROB index width.

Ports:
- clock  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- nuke  in  1: synchronous flush (mispredict/exception).
- fu_results  in  NUM_FU x FU_RESULT: per port {valid, value[`XLEN], dest_prf[PRF_BITS], rob_idx[ROB_BITS]}.
- fu_stall  out  1: when high, FUs hold results; fu_results ignored this cycle.
- cdb_output  out  N x CDB: registered broadcast {valid, value, dest_prf, rob_idx}.
- buffer_count  out  $clog2(DEPTH)+1: current occupancy, for debug/perf.

Behaviour:
- State: circular queue of DEPTH entries, head, tail, count (registered).
- Reset (async, immediate): head=tail=count=0, all cdb_output[i].valid=0, all payload fields 0; hence fu_stall=0.
- fu_stall = (count > DEPTH-NUM_FU); purely from registered count, no input dependence. Conservative; guarantees no overflow.
- Per cycle, when not stalled and not nuke: candidate list = queued entries oldest-first (head onward), then incoming valid fu_results in ascending port index.
  - First min(N, total) candidates load cdb_output lanes 0..k-1 at the edge; lanes k..N-1 get valid=0.
  - Remaining incoming candidates are appended at tail in port order.
- Latency: with an empty queue, a result valid in cycle t appears on cdb_output after the edge ending cycle t (1 edge). A queued result broadcasts when it reaches the first N candidates.
- When stalled: fu_results are not sampled; queue still drains up to N entries per cycle.
- Ordering rules:
  - No result is broadcast before an older one.
  - Lane index = age order within a cycle.
  - Same-cycle inputs are ordered by port index.
- count_next = count - popped_from_queue + pushed; head/tail wrap modulo DEPTH.
- Invalid (valid=0) fu_results lanes are never queued; gaps between valid ports are compacted.
- nuke: at the edge, head=tail=count=0 and all cdb valids=0. Incoming results that cycle are dropped. Outputs already on CDB during the nuke cycle remain visible that cycle.
- Simultaneous nuke with stall: nuke wins; fu_stall drops the next cycle.
- Reset mid-operation: all queued results are lost; no broadcast follows.
- Exactly full (count=DEPTH) is unreachable by construction; an assertion in RTL checks count<=DEPTH.

Decomposition:
- Shared package gains typedef FU_RESULT and reuses the existing CDB typedef, `N and `XLEN. Add `CDB_BUF_DEPTH.
- One sub-module, result_compactor: combinational; packs NUM_FU valid inputs into a dense, port-ordered list with count. Instantiated once.
- Queue/pop logic stays in the top module.

Test Plan:
- Reset then idle -> all cdb valid=0, fu_stall=0, buffer_count=0.
- Single result on port 3 {value=32'h4, dest_prf=6'h1, rob_idx=2} with empty queue -> next edge cdb_output[0] = that result, lanes 1-3 invalid, count=0.
- Ports 0,2,5,6,7 valid in one cycle -> next edge lanes 0-3 = ports 0,2,5,6; following edge lane 0 = port 7, lanes 1-3 invalid.
- All 8 ports valid for 3 consecutive cycles -> count reaches 12. Stall check: fu_stall asserts once count>8, new inputs are ignored while stalled, CDB drains 4/cycle, and every (dest_prf) is broadcast exactly once in issue order.
- Queue holding 6 entries, then nuke with 4 new valid inputs -> next edge count=0, cdb valids=0. No stale entry ever broadcasts; subsequent new result has 1-edge latency.
- Head/tail wraparound: stream 40 results over many cycles with random gaps -> broadcast order equals input order, no loss or duplication, count never exceeds 16.
